// File: rtl/axis_relu_maxpool.sv
// axis_relu_maxpool
// Streams signed MAC results in row-major order, applies ReLU, an arithmetic
// right shift and unsigned saturation, then 2x2 max-pools the quantised map.
// Even rows park their horizontal pair maxima in a half-width row buffer; odd
// rows combine with that buffer and emit one pooled sample per window.
//
// Handshake: a beat moves on either AXI-Stream port at a rising ACLK edge
// where tvalid and tready are both high. m_axis_* holds steady while
// m_axis_tvalid is high and m_axis_tready is low. s_axis_tready drops only
// when the offered beat would complete a window while the output register is
// full and is not being drained on this edge.
module axis_relu_maxpool #(
   parameter int DATA_WIDTH = 32,
   parameter int OUT_WIDTH  = 8,
   parameter int SHIFT      = 8,
   parameter int IMG_COLS   = 24,
   parameter int IMG_ROWS   = 24
) (
   input  logic                  ACLK,
   input  logic                  ARESETN,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic                  s_axis_tlast,
   output logic [OUT_WIDTH-1:0]  m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast,
   output logic                  frame_err
);

   // Column counter keeps at least two bits so col[CW-1:1] is a legal index.
   localparam int CW = (IMG_COLS > 2) ? $clog2(IMG_COLS) : 2;
   localparam int RW = (IMG_ROWS > 2) ? $clog2(IMG_ROWS) : 1;
   localparam int NW = IMG_COLS / 2;
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_COLS - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_ROWS - 1);

   logic [CW-1:0]        col;
   logic [RW-1:0]        row;
   logic                 run;
   logic [OUT_WIDTH-1:0] prev_q;
   logic [OUT_WIDTH-1:0] row_buf [0:NW-1];

   logic [OUT_WIDTH-1:0] q;
   logic [OUT_WIDTH-1:0] pair_max;
   logic [OUT_WIDTH-1:0] buf_rd;
   logic [OUT_WIDTH-1:0] pool_max;
   logic                 win_done;
   logic                 last_pix;
   logic                 early_last;
   logic                 accept;

   // ReLU, shift, then clamp to the largest unsigned OUT_WIDTH value.
   function automatic logic [OUT_WIDTH-1:0] quant(input logic [DATA_WIDTH-1:0] x);
      logic [DATA_WIDTH-1:0] s;
      s = x >> SHIFT;
      if (x[DATA_WIDTH-1])
         return '0;
      else if (|s[DATA_WIDTH-1:OUT_WIDTH])
         return '1;
      else
         return s[OUT_WIDTH-1:0];
   endfunction

   // Datapath for the beat on the input port and the backpressure decision.
   always_comb begin
      q             = quant(s_axis_tdata);
      pair_max      = (q > prev_q) ? q : prev_q;
      buf_rd        = row_buf[col[CW-1:1]];
      pool_max      = (pair_max > buf_rd) ? pair_max : buf_rd;
      win_done      = col[0] & row[0];
      last_pix      = (col == COL_LAST) && (row == ROW_LAST);
      early_last    = s_axis_tlast && !last_pix;
      s_axis_tready = run && !(win_done && m_axis_tvalid && !m_axis_tready);
      accept        = s_axis_tvalid && s_axis_tready;
   end

   // Input-ready enable rises on the first edge out of reset.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) run <= 1'b0;
      else          run <= 1'b1;
   end

   // Pixel position; an early tlast abandons the frame and restarts at (0,0).
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         col <= '0;
         row <= '0;
      end else if (accept) begin
         if (early_last) begin
            col <= '0;
            row <= '0;
         end else if (col == COL_LAST) begin
            col <= '0;
            row <= (row == ROW_LAST) ? '0 : row + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
      end
   end

   // Pair and row-buffer storage; always written before read within a frame.
   always_ff @(posedge ACLK) begin
      if (accept && !col[0])
         prev_q <= q;
      if (accept && col[0] && !row[0] && !early_last)
         row_buf[col[CW-1:1]] <= pair_max;
   end

   // Output register: drain on ready, reload when a window completes.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tlast  <= 1'b0;
      end else begin
         if (m_axis_tready)
            m_axis_tvalid <= 1'b0;
         if (accept && win_done && !early_last) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= pool_max;
            m_axis_tlast  <= last_pix;
         end
      end
   end

   // Framing error: tlast present on the wrong beat or absent on the last.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) frame_err <= 1'b0;
      else          frame_err <= accept && (s_axis_tlast != last_pix);
   end

endmodule

// File: tb/tb_axis_relu_maxpool.sv
// tb_axis_relu_maxpool
// 4x4 feature map, OUT_WIDTH=8. dut0 uses SHIFT=0, dut8 uses SHIFT=8; sel
// picks which one receives input beats and is observed.
module tb_axis_relu_maxpool;

   logic               clk;
   logic               rst_n;
   logic signed [31:0] s_data;
   logic               s_valid;
   logic               s_last;
   logic               m_ready;
   logic               sel;

   logic       tr0, mv0, ml0, fe0;
   logic [7:0] md0;
   logic       tr1, mv1, ml1, fe1;
   logic [7:0] md1;

   logic       tready, mv, ml, fe;
   logic [7:0] md;

   logic [8:0]         exp_q[$];
   logic signed [31:0] frame_buf [0:15];
   bit                 stalled [0:15];
   int                 n_checks = 0;
   int                 n_fail   = 0;
   int                 err_cnt  = 0;

   axis_relu_maxpool #(.DATA_WIDTH(32), .OUT_WIDTH(8), .SHIFT(0), .IMG_COLS(4), .IMG_ROWS(4)) dut0 (
      .ACLK(clk), .ARESETN(rst_n),
      .s_axis_tdata(s_data), .s_axis_tvalid(s_valid && !sel), .s_axis_tready(tr0), .s_axis_tlast(s_last),
      .m_axis_tdata(md0), .m_axis_tvalid(mv0), .m_axis_tready(m_ready), .m_axis_tlast(ml0),
      .frame_err(fe0)
   );

   axis_relu_maxpool #(.DATA_WIDTH(32), .OUT_WIDTH(8), .SHIFT(8), .IMG_COLS(4), .IMG_ROWS(4)) dut8 (
      .ACLK(clk), .ARESETN(rst_n),
      .s_axis_tdata(s_data), .s_axis_tvalid(s_valid && sel), .s_axis_tready(tr1), .s_axis_tlast(s_last),
      .m_axis_tdata(md1), .m_axis_tvalid(mv1), .m_axis_tready(m_ready), .m_axis_tlast(ml1),
      .frame_err(fe1)
   );

   assign tready = sel ? tr1 : tr0;
   assign mv     = sel ? mv1 : mv0;
   assign md     = sel ? md1 : md0;
   assign ml     = sel ? ml1 : ml0;
   assign fe     = sel ? fe1 : fe0;

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference quantiser
   function automatic logic [7:0] q_ref(input logic signed [31:0] x, input int sh);
      logic signed [31:0] v;
      if (x < 0) return 8'd0;
      v = x >>> sh;
      if (v > 255) return 8'd255;
      return v[7:0];
   endfunction

   // push the four pooled results of frame_buf
   task automatic push_frame_expect(input int sh);
      logic [7:0] m, t;
      logic       l;
      for (int wr = 0; wr < 2; wr++)
         for (int wc = 0; wc < 2; wc++) begin
            m = 8'd0;
            for (int dr = 0; dr < 2; dr++)
               for (int dc = 0; dc < 2; dc++) begin
                  t = q_ref(frame_buf[(2*wr+dr)*4 + 2*wc + dc], sh);
                  if (t > m) m = t;
               end
            l = (wr == 1) && (wc == 1);
            exp_q.push_back({l, m});
         end
   endtask

   // scoreboard / monitor
   initial begin
      logic [8:0] e;
      logic [9:0] hold_val;
      bit         hold_chk;
      hold_chk = 0;
      hold_val = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            hold_chk = 0;
         end else begin
            if (fe) err_cnt++;
            if (hold_chk) begin
               n_checks++;
               if ({mv, ml, md} !== hold_val) begin
                  n_fail++;
                  $display("FAIL hold_stable: got v=%0b l=%0b d=%0d, expected v=%0b l=%0b d=%0d",
                           mv, ml, md, hold_val[9], hold_val[8], hold_val[7:0]);
               end
            end
            hold_chk = mv && !m_ready;
            hold_val = {mv, ml, md};
            if (mv && m_ready) begin
               n_checks++;
               if (exp_q.size() == 0) begin
                  n_fail++;
                  $display("FAIL out_unexpected: got last=%0b data=%0d, expected no output", ml, md);
               end else begin
                  e = exp_q.pop_front();
                  if ({ml, md} !== e) begin
                     n_fail++;
                     $display("FAIL out_data: got last=%0b data=%0d, expected last=%0b data=%0d",
                              ml, md, e[8], e[7:0]);
                  end
               end
            end
         end
      end
   end

   // driver tasks
   task automatic send_beat(input logic signed [31:0] d, input logic l, input int idx);
      int   cyc;
      logic ok;
      s_data  = d;
      s_last  = l;
      s_valid = 1'b1;
      cyc     = 0;
      ok      = 1'b0;
      while (!ok && cyc < 200) begin
         @(negedge clk);
         ok = tready;
         if (!ok) stalled[idx] = 1;
         @(posedge clk);
         #1;
         cyc++;
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      if (!ok) begin
         n_checks++;
         n_fail++;
         $display("FAIL send_timeout: beat %0d tready=0 for %0d cycles, expected acceptance", idx, cyc);
      end
   endtask

   task automatic send_frame(input int n, input int last_idx);
      for (int i = 0; i < 16; i++) stalled[i] = 0;
      for (int i = 0; i < n; i++) send_beat(frame_buf[i], i == last_idx, i);
   endtask

   task automatic wait_drain(input string name);
      int c;
      c = 0;
      while (exp_q.size() != 0 && c < 200) begin
         @(posedge clk);
         #1;
         c++;
      end
      repeat (4) @(posedge clk);
      #1;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL %s_drain: %0d outputs outstanding, expected 0", name, exp_q.size());
      end
   endtask

   task automatic check_err(input string name, input int got, input int want);
      // plain inline count check kept per call site below
   endtask

   task automatic do_reset(input int cycles);
      rst_n   = 1'b0;
      s_valid = 1'b0;
      s_last  = 1'b0;
      repeat (cycles) begin
         @(negedge clk);
         n_checks++;
         if ({tr0, mv0, ml0, md0, fe0, tr1, mv1, ml1, md1, fe1} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got tr=%0b v=%0b l=%0b d=%0d fe=%0b, expected all 0",
                     tr0, mv0, ml0, md0, fe0);
         end
      end
      exp_q.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      n_checks++;
      if (tready !== 1'b0) begin
         n_fail++;
         $display("FAIL ready_before_edge: got %0b, expected 0", tready);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (tready !== 1'b1) begin
         n_fail++;
         $display("FAIL ready_after_edge: got %0b, expected 1", tready);
      end
   endtask

   // scenarios
   task automatic test_reset;
      sel     = 1'b0;
      m_ready = 1'b1;
      do_reset(3);
   endtask

   task automatic test_ramp;
      int e0;
      e0 = err_cnt;
      for (int i = 0; i < 16; i++) frame_buf[i] = i + 1;
      push_frame_expect(0);
      send_frame(16, 15);
      wait_drain("ramp");
      n_checks++;
      if (err_cnt - e0 != 0) begin
         n_fail++;
         $display("FAIL ramp_frame_err: got %0d pulses, expected 0", err_cnt - e0);
      end
   endtask

   task automatic test_negative;
      for (int i = 0; i < 16; i++) frame_buf[i] = -5;
      push_frame_expect(0);
      send_frame(16, 15);
      wait_drain("negative");
   endtask

   task automatic test_random;
      for (int f = 0; f < 3; f++) begin
         for (int i = 0; i < 16; i++) frame_buf[i] = $signed($urandom_range(0, 2000)) - 1000;
         push_frame_expect(0);
         send_frame(16, 15);
      end
      wait_drain("random");
   endtask

   task automatic test_saturation;
      sel = 1'b1;
      for (int i = 0; i < 16; i++) frame_buf[i] = 32'h0001_0000;
      push_frame_expect(8);
      send_frame(16, 15);
      for (int i = 0; i < 16; i++) frame_buf[i] = 32'h0000_0300;
      push_frame_expect(8);
      send_frame(16, 15);
      for (int i = 0; i < 16; i++) frame_buf[i] = $signed($urandom_range(0, 32'h000A_0000)) - 32'h0003_0000;
      push_frame_expect(8);
      send_frame(16, 15);
      wait_drain("saturation");
      sel = 1'b0;
   endtask

   task automatic test_back_to_back;
      int e0, c;
      e0 = err_cnt;
      c  = 0;
      m_ready = 1'b1;
      for (int i = 0; i < 16; i++) frame_buf[i] = i + 1;
      push_frame_expect(0);
      fork
         send_frame(16, 15);
         begin
            while (!mv0 && c < 50) begin
               @(posedge clk);
               #1;
               c++;
            end
            m_ready = 1'b0;
            repeat (10) @(posedge clk);
            #1;
            m_ready = 1'b1;
         end
      join
      wait_drain("back_to_back");
      n_checks++;
      if (stalled[7] !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_stall_win2: got stall=%0b on beat 8, expected 1", stalled[7]);
      end
      n_checks++;
      if (stalled[6] !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_no_stall: got stall=%0b on beat 7, expected 0", stalled[6]);
      end
      n_checks++;
      if (err_cnt - e0 != 0) begin
         n_fail++;
         $display("FAIL b2b_frame_err: got %0d pulses, expected 0", err_cnt - e0);
      end
   endtask

   task automatic test_early_tlast;
      int e0;
      e0 = err_cnt;
      for (int i = 0; i < 16; i++) frame_buf[i] = 100 + i;
      send_frame(6, 5);
      for (int i = 0; i < 16; i++) frame_buf[i] = i + 1;
      push_frame_expect(0);
      send_frame(16, 15);
      wait_drain("early_tlast");
      n_checks++;
      if (err_cnt - e0 != 1) begin
         n_fail++;
         $display("FAIL early_tlast_err: got %0d pulses, expected 1", err_cnt - e0);
      end
   endtask

   task automatic test_missing_tlast;
      int e0;
      e0 = err_cnt;
      for (int i = 0; i < 16; i++) frame_buf[i] = 16 - i;
      push_frame_expect(0);
      send_frame(16, -1);
      for (int i = 0; i < 16; i++) frame_buf[i] = i + 1;
      push_frame_expect(0);
      send_frame(16, 15);
      wait_drain("missing_tlast");
      n_checks++;
      if (err_cnt - e0 != 1) begin
         n_fail++;
         $display("FAIL missing_tlast_err: got %0d pulses, expected 1", err_cnt - e0);
      end
   endtask

   task automatic test_reset_midframe;
      m_ready = 1'b1;
      for (int i = 0; i < 16; i++) frame_buf[i] = i + 1;
      exp_q.push_back({1'b0, 8'd6});
      exp_q.push_back({1'b0, 8'd8});
      send_frame(9, -1);
      wait_drain("midframe_pre");
      do_reset(3);
      // a held, undelivered output must vanish with reset
      m_ready = 1'b0;
      send_frame(6, -1);
      repeat (2) @(posedge clk);
      #1;
      do_reset(2);
      m_ready = 1'b1;
      push_frame_expect(0);
      send_frame(16, 15);
      wait_drain("midframe_post");
   endtask

   initial begin
      rst_n   = 1'b0;
      s_data  = '0;
      s_valid = 1'b0;
      s_last  = 1'b0;
      m_ready = 1'b1;
      sel     = 1'b0;
      test_reset;
      test_ramp;
      test_negative;
      test_random;
      test_saturation;
      test_back_to_back;
      test_early_tlast;
      test_missing_tlast;
      test_reset_midframe;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
